waveform_analyzer: RTL

- Receive-side companion to the function generator: consumes its 8-bit sample stream and measures the waveform.
- Detects rising mid-level crossings with hysteresis, and measures the period in accepted samples.
- Tracks min/max over each period and reports amplitude.
- Used in self-check loops and on-chip measurement of generated waveforms.

---
 rtl/waveform_analyzer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/waveform_analyzer.sv
// waveform_analyzer
//   Receive-side measurement block for an unsigned sample stream. Detects
//   rising mid-level crossings with hysteresis, counts accepted samples
//   between consecutive crossings and tracks min/max over each interval.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   sample_valid  sample qualifier; a sample is accepted on an edge where it is 1
//   sample        unsigned waveform sample
//   meas_valid    one-cycle pulse: a new measurement is on the outputs
//   period        accepted samples between consecutive rising events
//   min_val       minimum over the measured interval
//   max_val       maximum over the measured interval
//   amplitude     max_val - min_val
//   timeout       level; set on period counter saturation, cleared by the
//                 next meas_valid
module waveform_analyzer #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16,
  parameter int MID    = 128,
  parameter int HYST   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  output logic              meas_valid,
  output logic [CNT_W-1:0]  period,
  output logic [DATA_W-1:0] min_val,
  output logic [DATA_W-1:0] max_val,
  output logic [DATA_W-1:0] amplitude,
  output logic              timeout
);

  localparam logic [DATA_W-1:0] ARM_LVL  = DATA_W'(MID - HYST);
  localparam logic [DATA_W-1:0] FIRE_LVL = DATA_W'(MID + HYST);

  typedef enum logic {ACQUIRE, MEASURE} state_t;

  state_t              state_q, state_d;
  logic                armed_q, armed_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   run_min_q, run_min_d;
  logic [DATA_W-1:0]   run_max_q, run_max_d;
  logic                meas_valid_q, meas_valid_d;
  logic [CNT_W-1:0]    period_q, period_d;
  logic [DATA_W-1:0]   min_val_q, min_val_d;
  logic [DATA_W-1:0]   max_val_q, max_val_d;
  logic [DATA_W-1:0]   amplitude_q, amplitude_d;
  logic                timeout_q, timeout_d;

  // Band classification of the incoming sample; the band between the two
  // levels leaves the arm state untouched.
  logic below, above, rise, cnt_full, saturate;

  assign below    = sample < ARM_LVL;
  assign above    = sample >= FIRE_LVL;
  assign rise     = sample_valid && armed_q && above;
  assign cnt_full = (cnt_q == {CNT_W{1'b1}});
  assign saturate = sample_valid && (state_q == MEASURE) && !rise && cnt_full;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ACQUIRE;
    else      state_q <= state_d;
  end

  // Next-state logic
  // NOTE: every combinational output gets a default first so no latch is
  // inferred on paths that do not assign it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACQUIRE: if (rise)     state_d = MEASURE;
      MEASURE: if (saturate) state_d = ACQUIRE;
      default:               state_d = ACQUIRE;
    endcase
  end

  // Datapath / output next-values
  always_comb begin
    armed_d      = armed_q;
    cnt_d        = cnt_q;
    run_min_d    = run_min_q;
    run_max_d    = run_max_q;
    meas_valid_d = 1'b0;
    period_d     = period_q;
    min_val_d    = min_val_q;
    max_val_d    = max_val_q;
    amplitude_d  = amplitude_q;
    timeout_d    = timeout_q;

    if (sample_valid) begin
      // A single sample can only satisfy one of below/above, so it can never
      // both arm and fire.
      if (rise)       armed_d = 1'b0;
      else if (below) armed_d = 1'b1;

      if (rise) begin
        if (state_q == MEASURE) begin
          // Interval is [previous event, this event): the event sample itself
          // starts the next interval rather than closing this one.
          meas_valid_d = 1'b1;
          period_d     = cnt_q;
          min_val_d    = run_min_q;
          max_val_d    = run_max_q;
          amplitude_d  = run_max_q - run_min_q;
          timeout_d    = 1'b0;
        end
        cnt_d     = CNT_W'(1);
        run_min_d = sample;
        run_max_d = sample;
      end else if (state_q == MEASURE) begin
        if (cnt_full) begin
          // Interval too long to measure: abandon it and re-acquire from a
          // fresh arm; the last good measurement stays on the outputs.
          timeout_d = 1'b1;
          cnt_d     = '0;
          armed_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (sample < run_min_q) run_min_d = sample;
          if (sample > run_max_q) run_max_d = sample;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed_q      <= 1'b0;
      cnt_q        <= '0;
      run_min_q    <= {DATA_W{1'b1}};
      run_max_q    <= '0;
      meas_valid_q <= 1'b0;
      period_q     <= '0;
      min_val_q    <= '0;
      max_val_q    <= '0;
      amplitude_q  <= '0;
      timeout_q    <= 1'b0;
    end else begin
      armed_q      <= armed_d;
      cnt_q        <= cnt_d;
      run_min_q    <= run_min_d;
      run_max_q    <= run_max_d;
      meas_valid_q <= meas_valid_d;
      period_q     <= period_d;
      min_val_q    <= min_val_d;
      max_val_q    <= max_val_d;
      amplitude_q  <= amplitude_d;
      timeout_q    <= timeout_d;
    end
  end

  assign meas_valid = meas_valid_q;
  assign period     = period_q;
  assign min_val    = min_val_q;
  assign max_val    = max_val_q;
  assign amplitude  = amplitude_q;
  assign timeout    = timeout_q;

endmodule
